// File: rtl/scmp_pkg.sv
// scmp_pkg: shared bus widths and memory-slave FSM state encoding for the SC/MP memory interface
package scmp_pkg;

    localparam int SCMP_ADDR_W = 12;
    localparam int SCMP_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LATCHED,
        RD_WAIT,
        RD_VALID,
        WR_DONE
    } state_t;

endpackage

// File: rtl/scmp_bram.sv
// scmp_bram: single-port synchronous byte RAM, 1-cycle read latency, write-first
module scmp_bram
    import scmp_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          addr,
    input  logic [SCMP_DATA_W-1:0] wdata,
    output logic [SCMP_DATA_W-1:0] rdata
);

    logic [SCMP_DATA_W-1:0] mem [2**AW];

    // write updates the array and forwards the new byte; otherwise read the addressed byte
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/scmp_mem_if.sv
// scmp_mem_if: SC/MP bus memory slave with read wait states; SCMP_MEM_WPROT_EN write-protects [0, ROM_TOP)
module scmp_mem_if
    import scmp_pkg::*;
#(
    parameter int AW          = 12,
    parameter int WAIT_STATES = 1,
    parameter int ROM_TOP     = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SCMP_ADDR_W-1:0] addr,
    input  logic                   ads_n,
    input  logic                   rds_n,
    input  logic                   wds_n,
    input  logic [SCMP_DATA_W-1:0] dout,
    output logic [SCMP_DATA_W-1:0] din,
    output logic                   hold_n,
    output logic                   busy,
    output logic                   err
);

`ifdef SCMP_MEM_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif
    localparam int CW = $clog2(WAIT_STATES + 1);

    state_t                 state, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [CW-1:0]          cnt, cnt_d;
    logic                   hold_d, err_d, ads_q, we;
    logic [SCMP_DATA_W-1:0] din_d, rdata;
    logic                   ads_fall, prot, unused_addr;

    assign ads_fall    = ads_q & ~ads_n;
    assign prot        = WPROT && (int'(addr_q) < ROM_TOP);
    assign busy        = state != IDLE;
    assign unused_addr = ^addr;

    scmp_bram #(.AW(AW)) u_bram (
        .clk   (clk),
        .we    (we),
        .addr  (addr_q),
        .wdata (dout),
        .rdata (rdata)
    );

    // state, address latch, wait counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
            cnt    <= '0;
            hold_n <= 1'b1;
            din    <= '0;
            err    <= 1'b0;
            ads_q  <= 1'b1;
        end else begin
            state  <= state_d;
            addr_q <= addr_d;
            cnt    <= cnt_d;
            hold_n <= hold_d;
            din    <= din_d;
            err    <= err_d;
            ads_q  <= ads_n;
        end
    end

    // next state; a new address strobe overrides whatever access is in flight
    always_comb begin
        state_d = state;
        addr_d  = addr_q;
        cnt_d   = cnt;
        hold_d  = hold_n;
        din_d   = din;
        err_d   = err;
        we      = 1'b0;
        if (ads_fall) begin
            addr_d  = addr[AW-1:0];
            state_d = LATCHED;
            if (state != IDLE) begin
                err_d  = 1'b1;
                hold_d = 1'b1;
            end
        end else begin
            case (state)
                LATCHED: begin
                    if (!rds_n && !wds_n) begin
                        err_d = 1'b1;
                    end else if (!rds_n) begin
                        state_d = RD_WAIT;
                        cnt_d   = CW'(WAIT_STATES);
                        hold_d  = 1'b0;
                    end else if (!wds_n) begin
                        state_d = WR_DONE;
                        we      = ~prot;
                        err_d   = err | prot;
                    end
                end
                RD_WAIT: begin
                    cnt_d = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_d = RD_VALID;
                        hold_d  = 1'b1;
                        din_d   = rdata;
                    end
                end
                RD_VALID: state_d = rds_n ? IDLE : RD_VALID;
                WR_DONE:  state_d = wds_n ? IDLE : WR_DONE;
                default:  state_d = state;
            endcase
        end
    end

endmodule

// File: tb/tb_scmp_mem_if.sv
// tb_scmp_mem_if: directed transaction bench with a byte-array model checked every cycle
module tb_scmp_mem_if;
    import scmp_pkg::*;

    localparam int AW = 10, WS = 3, ROM_TOP = 256;
`ifdef SCMP_MEM_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [11:0] addr = '0;
    logic        ads_n = 1'b1, rds_n = 1'b1, wds_n = 1'b1;
    logic [7:0]  dout = '0;
    logic [7:0]  din;
    logic        hold_n, busy, err;

    int total = 0, bad = 0, lowcnt = 0;
    logic [7:0] mem [1024];
    bit known [1024];
    logic       exp_hold = 1'b1, exp_busy = 1'b0, exp_err = 1'b0;
    logic [7:0] exp_din = 8'h00;
    bit         din_ok = 1'b1, chk = 1'b0;

    always #5 clk = ~clk;

    scmp_mem_if #(.AW(AW), .WAIT_STATES(WS), .ROM_TOP(ROM_TOP)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .ads_n  (ads_n),
        .rds_n  (rds_n),
        .wds_n  (wds_n),
        .dout   (dout),
        .din    (din),
        .hold_n (hold_n),
        .busy   (busy),
        .err    (err)
    );

    task automatic cmp(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!hold_n) lowcnt++;
        if (chk) begin
            cmp("hold_n", 8'(hold_n), 8'(exp_hold));
            cmp("busy", 8'(busy), 8'(exp_busy));
            cmp("err", 8'(err), 8'(exp_err));
            if (din_ok) cmp("din", din, exp_din);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_addr(logic [11:0] a);
        addr  = a;
        ads_n = 1'b0;
        tick();
        ads_n = 1'b1;
        if (exp_busy) begin
            exp_err  = 1'b1;
            exp_hold = 1'b1;
        end
        exp_busy = 1'b1;
    endtask

    task automatic do_write(logic [11:0] a, logic [7:0] d, int extra);
        int idx;
        idx = int'(a[AW-1:0]);
        strobe_addr(a);
        dout  = d;
        wds_n = 1'b0;
        tick();
        if (WPROT && idx < ROM_TOP) exp_err = 1'b1;
        else begin
            mem[idx]   = d;
            known[idx] = 1'b1;
        end
        dout = ~d;
        repeat (extra) tick();
        wds_n = 1'b1;
        tick();
        exp_busy = 1'b0;
    endtask

    task automatic do_read(logic [11:0] a, int extra);
        int idx, s;
        idx = int'(a[AW-1:0]);
        strobe_addr(a);
        s     = lowcnt;
        rds_n = 1'b0;
        tick();
        exp_hold = 1'b0;
        for (int i = 1; i <= WS; i++) begin
            tick();
            if (i == WS) begin
                exp_hold = 1'b1;
                exp_din  = mem[idx];
                din_ok   = known[idx];
            end
        end
        repeat (extra) tick();
        rds_n = 1'b1;
        tick();
        exp_busy = 1'b0;
        cmp("hold_cycles", 8'(lowcnt - s), 8'(WS));
    endtask

    initial begin
        tick();
        chk = 1'b1;
        cmp("rst_din", din, 8'h00);
        rst_n = 1'b1;
        tick();

        wds_n = 1'b0;
        repeat (2) tick();
        wds_n = 1'b1;
        rds_n = 1'b0;
        repeat (2) tick();
        rds_n = 1'b1;
        tick();
        cmp("idle_strobe_busy", 8'(busy), 8'h00);

        do_write(12'h123, 8'hA5, 0);
        do_read(12'h123, 2);
        cmp("rd_123", din, 8'hA5);

        do_write(12'h7FF, 8'h3C, 1);
        do_read(12'h3FF, 0);
        cmp("wrap_3ff", din, 8'h3C);

        do_write(12'h200, 8'h5A, 6);
        do_read(12'h200, 1);
        cmp("long_wr", din, 8'h5A);

        do_read(12'h523, 0);
        cmp("sweep_523", din, 8'hA5);
        do_read(12'hFFF, 3);
        do_read(12'h200, 0);

        do_write(12'h010, 8'h55, 0);
        do_write(12'h100, 8'h55, 0);
        do_read(12'h100, 0);
        cmp("prot_100", din, 8'h55);
        cmp("prot_err", 8'(err), 8'(WPROT));
        do_read(12'h010, 0);

        strobe_addr(12'h123);
        dout  = 8'hEE;
        rds_n = 1'b0;
        wds_n = 1'b0;
        tick();
        exp_err = 1'b1;
        rds_n = 1'b1;
        wds_n = 1'b1;
        tick();
        cmp("both_err", 8'(err), 8'h01);
        do_read(12'h123, 0);
        cmp("both_ram", din, 8'hA5);

        strobe_addr(12'h3FF);
        rds_n = 1'b0;
        tick();
        exp_hold = 1'b0;
        tick();
        rds_n = 1'b1;
        strobe_addr(12'h3FF);
        cmp("abort_hold", 8'(hold_n), 8'h01);
        cmp("abort_din", din, 8'hA5);
        do_read(12'h3FF, 0);
        cmp("abort_rd", din, 8'h3C);

        strobe_addr(12'h123);
        rds_n = 1'b0;
        tick();
        exp_hold = 1'b0;
        tick();
        rst_n = 1'b0;
        rds_n = 1'b1;
        exp_hold = 1'b1;
        exp_busy = 1'b0;
        exp_err  = 1'b0;
        exp_din  = 8'h00;
        din_ok   = 1'b1;
        @(negedge clk);
        cmp("mid_rst_hold", 8'(hold_n), 8'h01);
        cmp("mid_rst_busy", 8'(busy), 8'h00);
        cmp("mid_rst_err", 8'(err), 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        do_read(12'h123, 0);
        cmp("ram_kept", din, 8'hA5);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
